// File: rtl/tt_prbs_pkg.sv
// Shared definitions for the PRBS16 stream checker: LFSR geometry, lock states,
// output view encodings and the feedback helper used by the predictor.
package tt_prbs_pkg;

    // x^16 + x^14 + x^13 + x^11 + 1, history shifts left with bit 0 newest
    localparam int LFSR_W = 16;
    localparam int TAP_A  = 15;
    localparam int TAP_B  = 13;
    localparam int TAP_C  = 12;
    localparam int TAP_D  = 10;

    // Saturation value of the error counter
    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    // Lock state machine; encodings are visible on the status view
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // uo_out view select encodings (ui_in[4:3])
    localparam logic [1:0] VIEW_STATUS  = 2'd0;
    localparam logic [1:0] VIEW_ERR_LO  = 2'd1;
    localparam logic [1:0] VIEW_ERR_HI  = 2'd2;
    localparam logic [1:0] VIEW_BIT_CNT = 2'd3;

    // Next bit predicted from the 16-bit history
    function automatic logic prbs_feedback(input logic [LFSR_W-1:0] sr);
        return sr[TAP_A] ^ sr[TAP_B] ^ sr[TAP_C] ^ sr[TAP_D];
    endfunction

endpackage

// File: rtl/prbs16_predict.sv
// History register of the PRBS16 checker. Holds the last 16 bits and predicts
// the next one. The shifted-in bit is either the received bit (while acquiring)
// or the prediction itself (flywheel while locked, so line errors never enter
// the history).
module prbs16_predict
    import tt_prbs_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_shift_en,
    input  logic i_load_pred,
    input  logic i_rx_bit,
    output logic o_pred,
    output logic o_sr_nonzero
);

    logic [LFSR_W-1:0] r_sr;
    logic [LFSR_W-1:0] w_sr_shifted;
    logic              w_pred;
    logic              w_shift_in;

    assign w_pred     = prbs_feedback(r_sr);
    assign w_shift_in = i_load_pred ? w_pred : i_rx_bit;

    // Shift-left network: new bit enters at position 0
    assign w_sr_shifted[0] = w_shift_in;
    genvar gi;
    generate
        for (gi = 1; gi < LFSR_W; gi++) begin : g_shift
            assign w_sr_shifted[gi] = r_sr[gi-1];
        end
    endgenerate

    // History register: cleared by reset, advances only on enabled valid bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_shift_en) begin
            r_sr <= w_sr_shifted;
        end
    end

    assign o_pred       = w_pred;
    assign o_sr_nonzero = |r_sr;

endmodule

// File: rtl/tt_um_prbs_checker.sv
// PRBS16 serial stream checker. Acquires the stream (HUNT fills history,
// VERIFY counts consecutive correct predictions), then flywheels in LOCKED
// while counting bit errors and dropping lock when too many errors land in
// one window of valid bits.
module tt_um_prbs_checker
    import tt_prbs_pkg::*;
#(
    parameter int LOCK_MATCHES = 32,
    parameter int LOSS_ERRORS  = 8,
    parameter int WINDOW       = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int FILL_W  = $clog2(LFSR_W);
    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W  = $clog2(LOSS_ERRORS + 1);

    state_t             r_state;
    logic [FILL_W-1:0]  r_fill_cnt;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [WERR_W-1:0]  r_win_err;
    logic [15:0]        r_err_cnt;
    logic [7:0]         r_bit_cnt;

    logic              w_valid;
    logic              w_clear;
    logic              w_rx_bit;
    logic              w_pred;
    logic              w_sr_nonzero;
    logic              w_locked;
    logic              w_mismatch;
    logic [WERR_W-1:0] w_win_err_sum;
    logic              w_loss;
    logic              w_win_wrap;
    logic              w_unused;

    assign w_valid    = ena & ui_in[1];
    assign w_clear    = ena & ui_in[2];
    assign w_rx_bit   = ui_in[0];
    assign w_locked   = (r_state == ST_LOCKED);
    assign w_mismatch = w_rx_bit ^ w_pred;

    // r_win_err stays below LOSS_ERRORS while locked, so the sum never overflows
    assign w_win_err_sum = r_win_err + WERR_W'(w_mismatch);
    assign w_loss        = (w_win_err_sum >= WERR_W'(LOSS_ERRORS));
    assign w_win_wrap    = (r_win_cnt == WIN_W'(WINDOW - 1));

    assign w_unused = &{1'b0, ui_in[7:5], uio_in};

    prbs16_predict u_predict (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_shift_en   (w_valid),
        .i_load_pred  (w_locked),
        .i_rx_bit     (w_rx_bit),
        .o_pred       (w_pred),
        .o_sr_nonzero (w_sr_nonzero)
    );

    // Lock state machine plus fill/match/window counters and the bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_fill_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_bit_cnt   <= '0;
        end else if (w_valid) begin
            r_bit_cnt <= r_bit_cnt + 8'd1;
            case (r_state)
                ST_HUNT: begin
                    if (r_fill_cnt == FILL_W'(LFSR_W - 1)) begin
                        r_state     <= ST_VERIFY;
                        r_fill_cnt  <= '0;
                        r_match_cnt <= '0;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    // An all-zero history predicts zeros forever; refuse to lock on it
                    if (!w_sr_nonzero || w_mismatch) begin
                        r_match_cnt <= '0;
                    end else if (r_match_cnt == MATCH_W'(LOCK_MATCHES - 1)) begin
                        r_state     <= ST_LOCKED;
                        r_match_cnt <= '0;
                        r_win_cnt   <= '0;
                        r_win_err   <= '0;
                    end else begin
                        r_match_cnt <= r_match_cnt + MATCH_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (w_loss) begin
                        r_state    <= ST_HUNT;
                        r_fill_cnt <= '0;
                        r_win_cnt  <= '0;
                        r_win_err  <= '0;
                    end else if (w_win_wrap) begin
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                        r_win_err <= w_win_err_sum;
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                end
            endcase
        end
    end

    // Saturating error counter; a clear wins over a same-cycle error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_clear) begin
            r_err_cnt <= '0;
        end else if (w_valid && w_locked && w_mismatch && (r_err_cnt != ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    // Output view mux over registered state, follows ui_in[4:3] immediately
    always_comb begin
        uo_out = 8'h00;
        case (ui_in[4:3])
            VIEW_STATUS:  uo_out = {5'b00000, w_locked, r_state};
            VIEW_ERR_LO:  uo_out = r_err_cnt[7:0];
            VIEW_ERR_HI:  uo_out = r_err_cnt[15:8];
            VIEW_BIT_CNT: uo_out = r_bit_cnt;
            default:      uo_out = 8'h00;
        endcase
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_prbs_checker.sv
// Scoreboard bench for tt_um_prbs_checker. Two instances run side by side:
// 'a' with default parameters for acquisition/loss/reset/enable scenarios and
// randomized traffic, 'b' with loss disabled so the error counter can be
// driven to saturation. Drivers push the reference model's expected view into
// a queue each cycle; per-instance monitors pop and compare after each edge.
module tb_tt_um_prbs_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a = 1'b0, ena_a = 1'b0;
    logic [7:0] ui_a = 8'h00, uio_in_a = 8'h00;
    logic [7:0] uo_a, uio_out_a, uio_oe_a;
    logic       rst_n_b = 1'b0, ena_b = 1'b0;
    logic [7:0] ui_b = 8'h00, uio_in_b = 8'h00;
    logic [7:0] uo_b, uio_out_b, uio_oe_b;

    tt_um_prbs_checker dut_a (
        .clk(clk), .rst_n(rst_n_a), .ena(ena_a), .ui_in(ui_a), .uo_out(uo_a),
        .uio_in(uio_in_a), .uio_out(uio_out_a), .uio_oe(uio_oe_a)
    );

    tt_um_prbs_checker #(.LOCK_MATCHES(32), .LOSS_ERRORS(200), .WINDOW(64)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .ena(ena_b), .ui_in(ui_b), .uo_out(uo_b),
        .uio_in(uio_in_b), .uio_out(uio_out_b), .uio_oe(uio_oe_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] exp;
        logic [1:0] sel;
        logic [7:0] phase;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // ---------------- reference model (index 0 = dut_a, 1 = dut_b) -------------
    // state: 0 hunt, 1 verify, 2 locked
    int m_state[2], m_fill[2], m_match[2], m_win[2], m_werr[2], m_err[2], m_bits[2];
    bit m_hist[2][16];   // m_hist[k][i] = bit received/predicted i+1 valid bits ago
    int m_loss[2];
    localparam int M_LOCK = 32;
    localparam int M_WIN  = 64;

    function automatic void hist_push(int k, bit b);
        for (int i = 15; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = b;
    endfunction

    function automatic void model_step(int k, bit rst, bit en, bit vld, bit din, bit clr);
        bit p;
        bit any;
        int e;
        if (!rst) begin
            m_state[k] = 0; m_fill[k] = 0; m_match[k] = 0; m_win[k] = 0;
            m_werr[k] = 0; m_err[k] = 0; m_bits[k] = 0;
            for (int i = 0; i < 16; i++) m_hist[k][i] = 1'b0;
            return;
        end
        if (!en) return;
        if (vld) begin
            m_bits[k] = (m_bits[k] + 1) % 256;
            p = m_hist[k][15] ^ m_hist[k][13] ^ m_hist[k][12] ^ m_hist[k][10];
            any = 1'b0;
            for (int i = 0; i < 16; i++) any |= m_hist[k][i];
            case (m_state[k])
                0: begin
                    hist_push(k, din);
                    m_fill[k]++;
                    if (m_fill[k] == 16) begin
                        m_state[k] = 1; m_fill[k] = 0; m_match[k] = 0;
                    end
                end
                1: begin
                    hist_push(k, din);
                    if (any && din == p) begin
                        m_match[k]++;
                        if (m_match[k] == M_LOCK) begin
                            m_state[k] = 2; m_match[k] = 0; m_win[k] = 0; m_werr[k] = 0;
                        end
                    end else begin
                        m_match[k] = 0;
                    end
                end
                default: begin
                    hist_push(k, p);
                    e = m_werr[k];
                    if (din != p) begin
                        e++;
                        if (m_err[k] < 65535) m_err[k]++;
                    end
                    if (e >= m_loss[k]) begin
                        m_state[k] = 0; m_fill[k] = 0; m_win[k] = 0; m_werr[k] = 0;
                    end else begin
                        m_win[k]  = (m_win[k] + 1) % M_WIN;
                        m_werr[k] = (m_win[k] == 0) ? 0 : e;
                    end
                end
            endcase
        end
        if (clr) m_err[k] = 0;
    endfunction

    function automatic logic [7:0] exp_view(int k, logic [1:0] sel);
        case (sel)
            2'd0:    return (m_state[k] == 2) ? 8'h06 : 8'(m_state[k]);
            2'd1:    return 8'(m_err[k] % 256);
            2'd2:    return 8'(m_err[k] / 256);
            default: return 8'(m_bits[k]);
        endcase
    endfunction

    // ---------------- PRBS16 stream source ----------------
    logic [15:0] g_sr[2];
    int          g_n[2];

    function automatic void gen_reset(int k, logic [15:0] seed);
        g_sr[k] = seed;
        g_n[k]  = 0;
    endfunction

    // First 16 bits are the seed, MSB first; then each bit is the XOR of the
    // bits 16, 14, 13 and 11 positions earlier in the stream.
    function automatic bit gen_bit(int k);
        bit b;
        logic [15:0] s;
        s = g_sr[k];
        if (g_n[k] < 16) begin
            b = s[15 - g_n[k]];
        end else begin
            b = s[15] ^ s[13] ^ s[12] ^ s[10];
            g_sr[k] = {s[14:0], b};
        end
        g_n[k]++;
        return b;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(int k, bit rst, bit en, bit vld, bit din, bit clr,
                         logic [1:0] sel, int ph);
        logic [2:0] junk;
        exp_t       x;
        @(negedge clk);
        junk = 3'($urandom);
        if (k == 0) begin
            rst_n_a = rst; ena_a = en; ui_a = {junk, sel, clr, vld, din};
            uio_in_a = 8'($urandom);
        end else begin
            rst_n_b = rst; ena_b = en; ui_b = {junk, sel, clr, vld, din};
            uio_in_b = 8'($urandom);
        end
        model_step(k, rst, en, vld, din, clr);
        x.exp   = exp_view(k, sel);
        x.sel   = sel;
        x.phase = 8'(ph);
        if (k == 0) q_a.push_back(x);
        else        q_b.push_back(x);
    endtask

    // One valid bit, optionally preceded by random idle (invalid) cycles
    task automatic send(int k, bit din, int ph, bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 3) == 0)
                drive(k, 1, 1, 0, 1'($urandom), 0, 2'($urandom), ph);
        end
        drive(k, 1, 1, 1, din, 0, 2'($urandom), ph);
    endtask

    task automatic send_clean(int k, int n, int ph, bit gaps);
        for (int i = 0; i < n; i++) send(k, gen_bit(k), ph, gaps);
    endtask

    // Idle cycle with a chosen view, used for targeted checks
    task automatic peek(int k, logic [1:0] sel, int ph);
        drive(k, 1, 1, 0, 1'($urandom), 0, sel, ph);
    endtask

    // ---------------- monitors ----------------
    exp_t ea, eb;

    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            checks++;
            if (uo_a !== ea.exp) begin
                failures++;
                $display("FAIL a_view phase=%0d sel=%0d uo_out=0x%02h expected=0x%02h",
                         ea.phase, ea.sel, uo_a, ea.exp);
            end
            checks++;
            if (uio_out_a !== 8'h00 || uio_oe_a !== 8'h00) begin
                failures++;
                $display("FAIL a_uio phase=%0d uio_out=0x%02h uio_oe=0x%02h expected=0x00/0x00",
                         ea.phase, uio_out_a, uio_oe_a);
            end
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            checks++;
            if (uo_b !== eb.exp) begin
                failures++;
                $display("FAIL b_view phase=%0d sel=%0d uo_out=0x%02h expected=0x%02h",
                         eb.phase, eb.sel, uo_b, eb.exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_a();
        bit b, en, vld, rst, clr;
        int rate;
        gen_reset(0, 16'hACE1);
        // reset overrides ena/ui_in, every view reads 0
        for (int i = 0; i < 4; i++)
            drive(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'(i), 1);
        $display("tb: a reset views checked");

        // acquisition: 16 fill + 32 matches
        send_clean(0, 47, 2, 1);
        peek(0, 2'd0, 2);
        send_clean(0, 1, 2, 1);
        peek(0, 2'd0, 2);
        peek(0, 2'd1, 2);
        peek(0, 2'd3, 2);
        $display("tb: a lock after 48 clean bits, status=0x%02h", exp_view(0, 2'd0));

        // isolated errors
        for (int e = 0; e < 3; e++) begin
            send(0, ~gen_bit(0), 3, 1);
            peek(0, 2'd1, 3);
            send_clean(0, 19, 3, 1);
        end
        peek(0, 2'd0, 3);
        peek(0, 2'd1, 3);
        $display("tb: a isolated errors, err_cnt=%0d", m_err[0]);

        // burst of 8 errors at a window start forces loss, then relock
        while (m_win[0] != 0) send(0, gen_bit(0), 4, 1);
        for (int e = 0; e < 8; e++) begin
            send(0, ~gen_bit(0), 4, 1);
            peek(0, 2'd0, 4);
        end
        send_clean(0, 47, 5, 1);
        peek(0, 2'd0, 5);
        send_clean(0, 1, 5, 1);
        peek(0, 2'd0, 5);
        $display("tb: a loss and relock, status=0x%02h", exp_view(0, 2'd0));

        // all-zero stream never locks
        drive(0, 0, 1, 0, 0, 0, 2'd0, 6);
        for (int i = 0; i < 500; i++) send(0, 1'b0, 6, 0);
        peek(0, 2'd0, 6);
        $display("tb: a all-zero stream, status=0x%02h", exp_view(0, 2'd0));

        // clear overrides same-cycle error
        drive(0, 0, 1, 0, 0, 0, 2'd0, 7);
        gen_reset(0, 16'hACE1);
        send_clean(0, 48, 7, 0);
        send(0, ~gen_bit(0), 7, 0);
        send(0, ~gen_bit(0), 7, 0);
        peek(0, 2'd1, 7);
        drive(0, 1, 1, 1, ~gen_bit(0), 1, 2'd1, 7);
        peek(0, 2'd1, 7);
        $display("tb: a clear with same-cycle error, err_cnt=%0d", m_err[0]);

        // ena low freezes everything
        send(0, ~gen_bit(0), 8, 0);
        for (int i = 0; i < 100; i++)
            drive(0, 1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 8);
        for (int i = 0; i < 4; i++) peek(0, 2'(i), 8);
        $display("tb: a ena=0 hold");

        // reset while locked
        drive(0, 0, 1, 1, gen_bit(0), 0, 2'd0, 9);
        peek(0, 2'd0, 9);
        send_clean(0, 20, 9, 1);
        $display("tb: a reset mid-lock");

        // randomized traffic: light then heavy error rate, sporadic clear/reset/ena
        for (int i = 0; i < 1000; i++) begin
            rate = (i < 500) ? 40 : 5;
            rst  = ($urandom_range(0, 399) != 0);
            en   = ($urandom_range(0, 9) != 0);
            vld  = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 59) == 0);
            b    = 1'($urandom);
            if (rst && en && vld) b = gen_bit(0) ^ ($urandom_range(0, rate - 1) == 0);
            drive(0, rst, en, vld, b, clr, 2'($urandom), 10);
        end
        $display("tb: a random traffic done");
    endtask

    task automatic run_b();
        gen_reset(1, 16'hACE1);
        drive(1, 0, 1, 1, 1, 0, 2'd0, 20);
        drive(1, 0, 1, 1, 1, 0, 2'd0, 20);
        send_clean(1, 48, 20, 0);
        peek(1, 2'd0, 20);
        // every bit inverted: 65540 errors, counter must stop at 0xFFFF
        for (int i = 0; i < 65540; i++)
            drive(1, 1, 1, 1, ~gen_bit(1), 0, (i % 2 == 0) ? 2'd1 : 2'd2, 21);
        peek(1, 2'd1, 21);
        peek(1, 2'd2, 21);
        peek(1, 2'd0, 21);
        drive(1, 1, 1, 1, ~gen_bit(1), 1, 2'd1, 22);
        peek(1, 2'd2, 22);
        send(1, ~gen_bit(1), 22, 0);
        peek(1, 2'd1, 22);
        $display("tb: b saturation and clear done");
    endtask

    initial begin
        m_loss[0] = 8;
        m_loss[1] = 200;
        for (int k = 0; k < 2; k++) model_step(k, 0, 0, 0, 0, 0);
        fork
            run_a();
            run_b();
        join
        repeat (3) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending_a=%0d pending_b=%0d expected=0/0",
                     q_a.size(), q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time=%0t limit=5000000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tt_um_prbs_checker.md
TT_UM_PRBS_CHECKER -- requirements
Module: tt_um_prbs_checker

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  synchronous active-low reset.
REQ-003 SHALL have: ena  input  1  design selected; when 0, all state holds.
REQ-004 SHALL have: ui_in  input  8  [0] serial data bit, [1] bit valid, [2] clear error counter (level), [4:3] output view select, [7:5] unused.
REQ-005 SHALL have: uo_out  output  8  view selected by ui_in[4:3].
REQ-006 SHALL have: uio_in  input  8  unused.
REQ-007 SHALL have: uio_out  output  8  constant 0.
REQ-008 SHALL have: uio_oe  output  8  constant 0 (all bidirectional pins inputs).
REQ-009 SHALL have: parameter LOCK_MATCHES, default 32, consecutive matches required to lock.
REQ-010 SHALL have: parameter LOSS_ERRORS, default 8, errors per window that force loss of lock.
REQ-011 SHALL have: parameter WINDOW, default 64, valid bits per error-rate window.

Function
REQ-012 SHALL check the serial stream of a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1; history register sr shifts left, sr[0] newest bit; predicted bit p = sr[15]^sr[13]^sr[12]^sr[10].
REQ-013 SHALL act only on cycles with ena=1 and ui_in[1]=1 (a "valid bit"); all other cycles hold every register.
REQ-014 SHALL implement states HUNT, VERIFY, LOCKED.
REQ-015 HUNT: shift received bit into sr, count fill bits; after the 16th valid bit -> VERIFY, match count 0.
REQ-016 VERIFY: shift received bit into sr; match (bit==p) increments match count, mismatch clears it.
REQ-017 VERIFY -> LOCKED when match count reaches LOCK_MATCHES and sr is nonzero; with sr all-zero the match count is held at 0 (all-zero stream never locks).
REQ-018 LOCKED: shift p (flywheel), not the received bit, into sr; a mismatch increments the error counter and the window error count.
REQ-019 LOCKED: window counter counts valid bits modulo WINDOW; window error count clears on wrap; reaching LOSS_ERRORS in one window -> HUNT on the same edge, fill count 0.
REQ-020 Error counter SHALL be 16 bits, saturating at 0xFFFF; ui_in[2]=1 with ena=1 clears it, overriding any same-cycle increment.
REQ-021 Bit counter SHALL be 8 bits, wrapping, incremented on every valid bit in any state.
REQ-022 uo_out view 0: {5'b0, locked, state[1:0]} with HUNT=0, VERIFY=1, LOCKED=2; view 1: error counter [7:0]; view 2: error counter [15:8]; view 3: bit counter.
REQ-023 uo_out SHALL be a combinational mux of registered values (same-cycle reflection of ui_in[4:3]; zero latency from register update to output).
REQ-024 Error counter SHALL reflect a mismatch one cycle after the valid bit's edge.

Reset
REQ-025 On rst_n=0 at a rising edge: state HUNT, sr 0, all counters 0, uo_out 0 in every view; reset overrides ena and ui_in.
REQ-026 Reset asserted mid-lock SHALL return to HUNT without retaining history.

Structure
REQ-027 Package tt_prbs_pkg SHALL hold the state enum, tap positions, LFSR width (16) and view-select encodings.
REQ-028 Sub-module prbs16_predict SHALL hold sr and compute p, with load-received/load-predicted select and shift enable.

Verification
REQ-029 Seed 0xACE1, 48 valid clean bits -> view 0 = 0x06 (locked, LOCKED) after bit 48 (16 fill + 32 matches); error counter 0.
REQ-030 Locked stream, invert 3 isolated bits 20 apart -> error counter 3, state stays LOCKED, no error propagation.
REQ-031 Locked stream, invert 8 bits within one 64-bit window -> HUNT on 8th error; relock after 48 further clean bits.
REQ-032 500 valid all-zero bits -> never leaves VERIFY, view 0 = 0x01.
REQ-033 Force 0xFFFF errors then more -> view 2/1 stay 0xFF/0xFF; assert ui_in[2] same cycle as an error -> counter 0.
REQ-034 ena=0 with toggling data/valid for 100 cycles -> all views unchanged; rst_n=0 while locked -> view 0 = 0x00 next cycle.
